// File: rtl/command_decoder.sv
// SUMP command frame assembler: short opcodes complete at once, long opcodes collect 4 LE argument bytes.
// Optional inter-byte timeout is built when CMD_TIMEOUT_EN is defined.
module command_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_error,
   output logic [7:0]  opcode,
   output logic [31:0] command,
   output logic        cmd_recv_rx,
   output logic        cmd_busy,
   output logic        cmd_abort
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ARGS = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  shadow_op_q, shadow_op_d;
   logic [31:0] shadow_arg_q, shadow_arg_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [31:0] command_q, command_d;
   logic        recv_q, recv_d;
   logic        busy_q;
   logic        abort_q, abort_d;

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc_s;

   // Saturating increment so the counter can never wrap back to zero
   always_comb begin
      if (tcnt_q == TLIMIT) begin
         tcnt_inc_s = tcnt_q;
      end else begin
         tcnt_inc_s = tcnt_q + TW'(1);
      end
   end
`endif

   // Next-state, shadow and output-register logic
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      shadow_op_d  = shadow_op_q;
      shadow_arg_d = shadow_arg_q;
      opcode_d     = opcode_q;
      command_d    = command_q;
      recv_d       = 1'b0;
      abort_d      = 1'b0;
`ifdef CMD_TIMEOUT_EN
      tcnt_d       = tcnt_q;
`endif
      case (state_q)
         IDLE: begin
            // A byte flagged with a framing error is dropped
            if (rx_valid && !rx_error) begin
               if (!rx_data[7]) begin
                  opcode_d  = rx_data;
                  command_d = 32'd0;
                  recv_d    = 1'b1;
               end else begin
                  shadow_op_d  = rx_data;
                  shadow_arg_d = 32'd0;
                  byte_cnt_d   = 2'd0;
                  state_d      = ARGS;
`ifdef CMD_TIMEOUT_EN
                  tcnt_d       = '0;
`endif
               end
            end else begin
               state_d = IDLE;
            end
         end
         ARGS: begin
            if (rx_error) begin
               abort_d = 1'b1;
               state_d = IDLE;
            end else if (rx_valid) begin
               shadow_arg_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
`ifdef CMD_TIMEOUT_EN
               tcnt_d = '0;
`endif
               if (byte_cnt_q == 2'd3) begin
                  opcode_d  = shadow_op_q;
                  command_d = {rx_data, shadow_arg_q[23:0]};
                  recv_d    = 1'b1;
                  state_d   = IDLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end else begin
`ifdef CMD_TIMEOUT_EN
               if (tcnt_inc_s == TLIMIT) begin
                  abort_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  tcnt_d = tcnt_inc_s;
               end
`else
               state_d = ARGS;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         byte_cnt_q   <= 2'd0;
         shadow_op_q  <= 8'd0;
         shadow_arg_q <= 32'd0;
         opcode_q     <= 8'd0;
         command_q    <= 32'd0;
         recv_q       <= 1'b0;
         busy_q       <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         shadow_op_q  <= shadow_op_d;
         shadow_arg_q <= shadow_arg_d;
         opcode_q     <= opcode_d;
         command_q    <= command_d;
         recv_q       <= recv_d;
         busy_q       <= (state_d == ARGS);
         abort_q      <= abort_d;
      end
   end

`ifdef CMD_TIMEOUT_EN
   // Inter-byte idle counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`endif

   assign opcode      = opcode_q;
   assign command     = command_q;
   assign cmd_recv_rx = recv_q;
   assign cmd_busy    = busy_q;
   assign cmd_abort   = abort_q;

endmodule
